// File: rtl/aespim_pkg.sv
// Shared definitions for the AES-PIM word accelerator and its key-expansion sequencer.
// Op codes are shared with the accelerator, so their encodings must not change.
package aespim_pkg;

   localparam int AES_NK        = 4;
   localparam int AES128_ROUNDS = 10;
   localparam int AES128_NW     = AES_NK * (AES128_ROUNDS + 1);

   typedef enum logic [2:0] {
      LD   = 3'd0,
      ST   = 3'd1,
      KEXR = 3'd2,
      KEX  = 3'd3
   } op_code_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } kexp_state_e;

   // Expansion op for emitted word 'step'; the last NK starts only drain the pipeline.
   function automatic op_code_e kexp_op(input logic [5:0] step);
      if (step >= 6'(AES_NK * AES128_ROUNDS))
         return ST;
      else if (step[1:0] == 2'd0)
         return KEXR;
      else
         return KEX;
   endfunction

endpackage

// File: rtl/aespim_kexp_ctrl.sv
// AES-128 key-expansion sequencer: loads 4 key words into the accelerator, streams 44 round-key words.
// Optional backpressure counter enabled by defining AESPIM_KEXP_STALL_CNT_EN.
module aespim_kexp_ctrl
   import aespim_pkg::*;
#(
   parameter int NK      = AES_NK,
   parameter int ROUNDS  = AES128_ROUNDS,
   parameter int STALL_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clear_i,
   input  logic               key_valid_i,
   output logic               key_ready_o,
   input  logic [31:0]        key_data_i,
   output logic               rk_valid_o,
   input  logic               rk_ready_i,
   output logic [31:0]        rk_data_o,
   output logic [5:0]         rk_idx_o,
   output logic [3:0]         rcon_idx_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               acc_start_o,
   output logic [2:0]         acc_op_o,
   output logic [31:0]        acc_data_o,
   input  logic [31:0]        acc_data_i,
   output logic [STALL_W-1:0] stall_cnt_o
);

   localparam int NW = NK * (ROUNDS + 1);

   kexp_state_e state_reg, state_next;
   logic [1:0]  ld_cnt_reg;
   logic [5:0]  step_reg;
   logic        key_fire;
   logic        rk_fire;
   logic        last_beat;
   logic        last_word;

   // key_ready_o already excludes clear_i; a clear cycle never counts as a handshake.
   assign key_fire  = key_valid_i & key_ready_o;
   assign rk_fire   = rk_valid_o & rk_ready_i & ~clear_i;
   assign last_beat = (ld_cnt_reg == 2'(NK - 1));
   assign last_word = (step_reg == 6'(NW - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg  <= IDLE;
         ld_cnt_reg <= '0;
         step_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (clear_i) begin
            ld_cnt_reg <= '0;
            step_reg   <= '0;
         end else begin
            if (key_fire)
               ld_cnt_reg <= last_beat ? 2'd0 : ld_cnt_reg + 2'd1;
            if (rk_fire)
               step_reg <= last_word ? 6'd0 : step_reg + 6'd1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      if (clear_i) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE, LOAD: if (key_fire) state_next = last_beat ? EMIT : LOAD;
            EMIT:       if (rk_fire && last_word) state_next = DONE;
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      key_ready_o = 1'b0;
      acc_start_o = 1'b0;
      acc_op_o    = LD;
      acc_data_o  = '0;
      rk_valid_o  = 1'b0;
      rk_data_o   = '0;
      rk_idx_o    = '0;
      done_o      = 1'b0;
      busy_o      = (state_reg != IDLE);
      rcon_idx_o  = step_reg[5:2];
      case (state_reg)
         IDLE, LOAD: begin
            key_ready_o = ~clear_i;
            acc_data_o  = key_data_i;
            acc_start_o = key_valid_i & ~clear_i;
         end
         EMIT: begin
            rk_valid_o  = 1'b1;
            rk_data_o   = acc_data_i;
            rk_idx_o    = step_reg;
            acc_op_o    = kexp_op(step_reg);
            // Shifting only on handshake keeps acc_data_i (and rk_data_o) frozen while stalled.
            acc_start_o = rk_ready_i & ~clear_i;
         end
         DONE:    done_o = 1'b1;
         default: ;
      endcase
   end

`ifdef AESPIM_KEXP_STALL_CNT_EN
   logic [STALL_W-1:0] stall_cnt_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         stall_cnt_reg <= '0;
      else if (clear_i || (state_reg != EMIT && state_next == EMIT))
         stall_cnt_reg <= '0;
      else if (rk_valid_o && !rk_ready_i && stall_cnt_reg != '1)
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
   end

   assign stall_cnt_o = stall_cnt_reg;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_aespim_kexp_ctrl.sv
// Directed self-checking bench for aespim_kexp_ctrl with a counting accelerator stub.
// Honors AESPIM_KEXP_STALL_CNT_EN for the stall counter expectation.
module tb_aespim_kexp_ctrl;
   import aespim_pkg::*;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        clear_i = 1'b0;
   logic        key_valid_i = 1'b0;
   logic        key_ready_o;
   logic [31:0] key_data_i = '0;
   logic        rk_valid_o;
   logic        rk_ready_i = 1'b0;
   logic [31:0] rk_data_o;
   logic [5:0]  rk_idx_o;
   logic [3:0]  rcon_idx_o;
   logic        busy_o;
   logic        done_o;
   logic        acc_start_o;
   logic [2:0]  acc_op_o;
   logic [31:0] acc_data_o;
   logic [31:0] acc_data_i;
   logic [15:0] stall_cnt_o;

   int total = 0;
   int bad = 0;

   // Stub accelerator: output word = C0DE0000 + number of starts seen since stub_clr.
   logic        stub_clr = 1'b0;
   logic [31:0] stub_cnt = '0;
   int          emit_starts = 0;
   logic [31:0] key_words [4] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};

   assign acc_data_i = 32'hC0DE0000 + stub_cnt;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (stub_clr) stub_cnt <= '0;
      else if (acc_start_o) stub_cnt <= stub_cnt + 1;
      if (rk_valid_o && acc_start_o) emit_starts <= emit_starts + 1;
   end

   aespim_kexp_ctrl dut (
      .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
      .key_valid_i(key_valid_i), .key_ready_o(key_ready_o), .key_data_i(key_data_i),
      .rk_valid_o(rk_valid_o), .rk_ready_i(rk_ready_i), .rk_data_o(rk_data_o),
      .rk_idx_o(rk_idx_o), .rcon_idx_o(rcon_idx_o), .busy_o(busy_o), .done_o(done_o),
      .acc_start_o(acc_start_o), .acc_op_o(acc_op_o), .acc_data_o(acc_data_o),
      .acc_data_i(acc_data_i), .stall_cnt_o(stall_cnt_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_stub();
      stub_clr = 1'b1;
      tick();
      stub_clr = 1'b0;
   endtask

   // Four key beats, 'gap' idle cycles after each; returns one cycle after the 4th beat.
   task automatic load_key(input int gap);
      for (int i = 0; i < 4; i++) begin
         key_valid_i = 1'b1;
         key_data_i  = key_words[i];
         #1;
         chk("ld_start", 32'(acc_start_o), 1);
         chk("ld_op", 32'(acc_op_o), 32'(LD));
         chk("ld_data", acc_data_o, key_words[i]);
         chk("ld_ready", 32'(key_ready_o), 1);
         tick();
         key_valid_i = 1'b0;
         key_data_i  = '0;
         if (i < 3) begin
            for (int g = 0; g < gap; g++) begin
               #1;
               chk("gap_nostart", 32'(acc_start_o), 0);
               chk("gap_busy", 32'(busy_o), 1);
               tick();
            end
         end
      end
      #1;
      $display("load done: rk_valid=%0d rk_idx=%0d", rk_valid_o, rk_idx_o);
      chk("emit_valid", 32'(rk_valid_o), 1);
      chk("emit_idx0", 32'(rk_idx_o), 0);
      chk("emit_keyrdy", 32'(key_ready_o), 0);
   endtask

   initial begin
      logic [2:0] exp_op;
      int         hs;
      int         cyc;
      int         start0;
      int         exp_stall;

      // Reset state
      #2;
      chk("rst_keyrdy", 32'(key_ready_o), 1);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_valid", 32'(rk_valid_o), 0);
      chk("rst_start", 32'(acc_start_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_stall", 32'(stall_cnt_o), 0);
      tick();
      rst_ni = 1'b1;
      clr_stub();

      // Test 1: full expansion with rk_ready held high
      load_key(0);
      rk_ready_i = 1'b1;
      for (int k = 0; k < 44; k++) begin
         #1;
         exp_op = (k >= 40) ? ST : ((k % 4 == 0) ? KEXR : KEX);
         $display("t1 step=%0d op=%0d data=%h", rk_idx_o, acc_op_o, rk_data_o);
         chk("t1_idx", 32'(rk_idx_o), 32'(k));
         chk("t1_op", 32'(acc_op_o), 32'(exp_op));
         chk("t1_data", rk_data_o, 32'hC0DE0000 + 32'(4 + k));
         chk("t1_start", 32'(acc_start_o), 1);
         chk("t1_rcon", 32'(rcon_idx_o), 32'(k / 4));
         chk("t1_nodone", 32'(done_o), 0);
         tick();
      end
      #1;
      chk("t1_done", 32'(done_o), 1);
      chk("t1_done_novalid", 32'(rk_valid_o), 0);
      tick();
      #1;
      chk("t1_done_once", 32'(done_o), 0);
      chk("t1_idle", 32'(busy_o), 0);
      rk_ready_i = 1'b0;

      // Test 2: random backpressure
      clr_stub();
      load_key(0);
      start0 = emit_starts;
      hs = 0;
      cyc = 0;
      while (hs < 44 && cyc < 2000) begin
         rk_ready_i = 1'($urandom_range(0, 1));
         #1;
         chk("t2_idx", 32'(rk_idx_o), 32'(hs));
         chk("t2_data", rk_data_o, 32'hC0DE0000 + 32'(4 + hs));
         chk("t2_start", 32'(acc_start_o), 32'(rk_ready_i));
         if (rk_ready_i) hs++;
         tick();
         cyc++;
      end
      chk("t2_hs_count", 32'(hs), 44);
      #1;
      chk("t2_emit_starts", 32'(emit_starts - start0), 44);
      chk("t2_done", 32'(done_o), 1);
      rk_ready_i = 1'b0;
      tick();

      // Test 3: gapped key beats; Test 4: clear at step 17
      clr_stub();
      load_key(2);
      rk_ready_i = 1'b1;
      for (int k = 0; k < 17; k++) tick();
      #1;
      chk("t4_idx17", 32'(rk_idx_o), 17);
      clear_i = 1'b1;
      #1;
      chk("t4_clr_nostart", 32'(acc_start_o), 0);
      tick();
      clear_i = 1'b0;
      rk_ready_i = 1'b0;
      #1;
      chk("t4_busy", 32'(busy_o), 0);
      chk("t4_valid", 32'(rk_valid_o), 0);
      chk("t4_keyrdy", 32'(key_ready_o), 1);
      chk("t4_rcon", 32'(rcon_idx_o), 0);
      clr_stub();
      load_key(0);
      chk("t4_restart_data", rk_data_o, 32'hC0DE0004);

      // Test 5: asynchronous reset in the middle of EMIT
      rk_ready_i = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      rst_ni = 1'b0;
      #1;
      chk("t5_valid", 32'(rk_valid_o), 0);
      chk("t5_busy", 32'(busy_o), 0);
      chk("t5_keyrdy", 32'(key_ready_o), 1);
      chk("t5_start", 32'(acc_start_o), 0);
      chk("t5_idx", 32'(rk_idx_o), 0);
      chk("t5_rcon", 32'(rcon_idx_o), 0);
      tick();
      rst_ni = 1'b1;
      rk_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t5_idle_nostart", 32'(acc_start_o), 0);
         tick();
      end

      // Test 6: five stall cycles at step 0
      clr_stub();
      load_key(0);
      chk("t6_stall0", 32'(stall_cnt_o), 0);
      for (int k = 0; k < 5; k++) begin
         chk("t6_hold_start", 32'(acc_start_o), 0);
         chk("t6_hold_data", rk_data_o, 32'hC0DE0004);
         tick();
         #1;
      end
`ifdef AESPIM_KEXP_STALL_CNT_EN
      exp_stall = 5;
`else
      exp_stall = 0;
`endif
      $display("t6 stall_cnt=%0d", stall_cnt_o);
      chk("t6_stall5", 32'(stall_cnt_o), 32'(exp_stall));
      chk("t6_idx", 32'(rk_idx_o), 0);
      rk_ready_i = 1'b1;
      cyc = 0;
      while (!done_o && cyc < 100) begin
         tick();
         #1;
         cyc++;
      end
      chk("t6_done", 32'(done_o), 1);
      rk_ready_i = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
